// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel/colour
// generators: pixel enable, raster position, video window, syncs, strobes
// and the completed-frame count.
interface vga_timing_gen_if #(
    parameter int CNT_WIDTH   = 11,
    parameter int FRAME_WIDTH = 8
);
    logic                   pix_ce;
    logic [CNT_WIDTH-1:0]   col;
    logic [CNT_WIDTH-1:0]   row;
    logic                   vid_on;
    logic                   hsync;
    logic                   vsync;
    logic                   line_start;
    logic                   frame_start;
    logic [FRAME_WIDTH-1:0] frame_cnt;

    // Timing generator side.
    modport master (
        output pix_ce, col, row, vid_on, hsync, vsync,
               line_start, frame_start, frame_cnt
    );

    // Consumer side (pixel/colour generators).
    modport slave (
        input  pix_ce, col, row, vid_on, hsync, vsync,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator running from a fast system clock.
// A divider produces the pixel clock enable; col/row counters advance on it
// and every decoded output is registered from the next-state counter values,
// so decode always lines up with the current position.
module vga_timing_gen #(
    parameter int HDISP       = 640,
    parameter int HFP         = 16,
    parameter int HPW         = 96,
    parameter int HBP         = 48,
    parameter int VDISP       = 480,
    parameter int VFP         = 10,
    parameter int VPW         = 2,
    parameter int VBP         = 33,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int PIX_DIV     = 1,
    parameter int CNT_WIDTH   = 11,
    parameter int FRAME_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,      // synchronous, active low
    input  logic             en,       // 0 freezes all timing state
    vga_timing_gen_if.master vga
);
    localparam int HTOT = HDISP + HFP + HPW + HBP;
    localparam int VTOT = VDISP + VFP + VPW + VBP;

    localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(HTOT - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(VTOT - 1);
    localparam logic [CNT_WIDTH-1:0] H_DISP   = CNT_WIDTH'(HDISP);
    localparam logic [CNT_WIDTH-1:0] V_DISP   = CNT_WIDTH'(VDISP);
    localparam logic [CNT_WIDTH-1:0] HS_START = CNT_WIDTH'(HDISP + HFP);
    localparam logic [CNT_WIDTH-1:0] HS_END   = CNT_WIDTH'(HDISP + HFP + HPW);
    localparam logic [CNT_WIDTH-1:0] VS_START = CNT_WIDTH'(VDISP + VFP);
    localparam logic [CNT_WIDTH-1:0] VS_END   = CNT_WIDTH'(VDISP + VFP + VPW);

    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    logic                   pix_ce;

    logic [CNT_WIDTH-1:0]   col_reg, col_next;
    logic [CNT_WIDTH-1:0]   row_reg, row_next;
    logic                   col_wrap, row_wrap;
    logic                   line_wrap, frame_wrap;

    logic                   vid_on_reg, vid_on_next;
    logic                   hsync_reg, hsync_next;
    logic                   vsync_reg, vsync_next;
    logic                   line_start_reg;
    logic                   frame_start_reg;
    logic [FRAME_WIDTH-1:0] frame_cnt_reg;

    // ------------------------------------------------------------------
    // Pixel clock enable. With a divide-by-one there is no divider state
    // at all and the enable is simply the run enable.
    // ------------------------------------------------------------------
    generate
        if (PIX_DIV == 1) begin : g_no_div
            assign pix_ce = en;
        end else begin : g_div
            localparam int DIV_W = $clog2(PIX_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

            logic [DIV_W-1:0] div_reg, div_next;

            // Divider next state: count while enabled, wrap after the last phase.
            always_comb begin
                div_next = div_reg;
                if (en) begin
                    if (div_reg == DIV_LAST) begin
                        div_next = '0;
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
            end

            // Divider state register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    div_reg <= '0;
                end else begin
                    div_reg <= div_next;
                end
            end

            // Enable drops in the same cycle as en, so a stop on the last
            // divider phase suppresses the advance.
            assign pix_ce = en && (div_reg == DIV_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    assign col_wrap   = (col_reg == H_LAST);
    assign row_wrap   = (row_reg == V_LAST);
    assign line_wrap  = pix_ce && col_wrap;
    assign frame_wrap = line_wrap && row_wrap;

    // Counter next state: col steps per pixel, row steps on each line wrap.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (pix_ce) begin
            if (col_wrap) begin
                col_next = '0;
                if (row_wrap) begin
                    row_next = '0;
                end else begin
                    row_next = row_reg + CNT_WIDTH'(1);
                end
            end else begin
                col_next = col_reg + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode from next-state counters so the registered outputs line up
    // with the registered position. vsync looks at row only, so it spans
    // whole lines.
    // ------------------------------------------------------------------
    always_comb begin
        vid_on_next = (col_next < H_DISP) && (row_next < V_DISP);

        if ((col_next >= HS_START) && (col_next < HS_END)) begin
            hsync_next = HS_ACT;
        end else begin
            hsync_next = !HS_ACT;
        end

        if ((row_next >= VS_START) && (row_next < VS_END)) begin
            vsync_next = VS_ACT;
        end else begin
            vsync_next = !VS_ACT;
        end
    end

    // Position and decoded-output registers. Reset parks the raster at the
    // last pixel of the frame (inside both back porches) so the first
    // advance lands on (0,0) with a full set of start strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_reg         <= H_LAST;
            row_reg         <= V_LAST;
            vid_on_reg      <= 1'b0;
            hsync_reg       <= !HS_ACT;
            vsync_reg       <= !VS_ACT;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            col_reg         <= col_next;
            row_reg         <= row_next;
            vid_on_reg      <= vid_on_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            line_start_reg  <= line_wrap;
            frame_start_reg <= frame_wrap;
        end
    end

    // Completed-frame counter, stepped on the same edge as frame_start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_reg <= '0;
        end else if (frame_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + FRAME_WIDTH'(1);
        end
    end

    assign vga.pix_ce      = pix_ce;
    assign vga.col         = col_reg;
    assign vga.row         = row_reg;
    assign vga.vid_on      = vid_on_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;
    assign vga.frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (divide-by-1 with a 2-bit frame
// counter, divide-by-4 with an 8-bit frame counter) on a small 10x6 raster.
// A reference model derives the expected position from the number of
// enabled clocks since reset; expected outputs are queued per edge and a
// monitor compares them against the DUT on the falling edge.
module tb_vga_timing_gen;
    localparam int HD = 6, HF = 1, HP = 1, HB = 2;
    localparam int VD = 2, VF = 1, VP = 1, VB = 2;
    localparam int HT = HD + HF + HP + HB;
    localparam int VT = VD + VF + VP + VB;
    localparam int PD1 = 1, FW1 = 2;
    localparam int PD2 = 4, FW2 = 8;
    localparam int CW = 8;

    typedef struct {
        int col;
        int row;
        int vid_on;
        int hsync;
        int vsync;
        int ls;
        int fs;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst1 = 1'b0, en1 = 1'b1;
    logic rst2 = 1'b0, en2 = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_WIDTH(CW), .FRAME_WIDTH(FW1)) if1 ();
    vga_timing_gen_if #(.CNT_WIDTH(CW), .FRAME_WIDTH(FW2)) if2 ();

    vga_timing_gen #(
        .HDISP(HD), .HFP(HF), .HPW(HP), .HBP(HB),
        .VDISP(VD), .VFP(VF), .VPW(VP), .VBP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .PIX_DIV(PD1),
        .CNT_WIDTH(CW), .FRAME_WIDTH(FW1)
    ) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .vga(if1.master)
    );

    vga_timing_gen #(
        .HDISP(HD), .HFP(HF), .HPW(HP), .HBP(HB),
        .VDISP(VD), .VFP(VF), .VPW(VP), .VBP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .PIX_DIV(PD2),
        .CNT_WIDTH(CW), .FRAME_WIDTH(FW2)
    ) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .vga(if2.master)
    );

    // Reference: e enabled clocks since reset give e/pd pixel advances from
    // the reset position (last pixel of the frame); adv says whether the
    // most recent edge was an advance.
    function automatic exp_t model(int e, bit adv, int pd, int fw);
        exp_t x;
        int lin, idx;
        lin      = (HT * VT - 1) + e / pd;
        idx      = lin % (HT * VT);
        x.col    = idx % HT;
        x.row    = idx / HT;
        x.fc     = (lin / (HT * VT)) % (1 << fw);
        x.vid_on = (x.col < HD && x.row < VD) ? 1 : 0;
        x.hsync  = (x.col >= HD + HF && x.col < HD + HF + HP) ? 0 : 1;
        x.vsync  = (x.row >= VD + VF && x.row < VD + VF + VP) ? 0 : 1;
        x.ls     = (adv && x.col == 0) ? 1 : 0;
        x.fs     = (adv && idx == 0) ? 1 : 0;
        return x;
    endfunction

    function automatic string fmt(exp_t x);
        return $sformatf("col=%0d row=%0d vid=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d",
                         x.col, x.row, x.vid_on, x.hsync, x.vsync, x.ls, x.fs, x.fc);
    endfunction

    task automatic check_state(string nm, exp_t want, exp_t got);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got {%s} want {%s}", nm, $time, fmt(got), fmt(want));
        end else begin
            $display("ok   %s t=%0t {%s}", nm, $time, fmt(got));
        end
    endtask

    task automatic check_bit(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
        end
    endtask

    // ---------------- reference model state, updated on each edge ----------
    int e1 = 0, e2 = 0;
    bit a1 = 1'b0, a2 = 1'b0;
    exp_t q1[$];
    exp_t q2[$];

    initial forever begin
        @(posedge clk);
        if (!rst1) begin
            e1 = 0; a1 = 1'b0;
        end else if (en1) begin
            a1 = (e1 % PD1 == PD1 - 1); e1++;
        end else begin
            a1 = 1'b0;
        end
        if (!rst2) begin
            e2 = 0; a2 = 1'b0;
        end else if (en2) begin
            a2 = (e2 % PD2 == PD2 - 1); e2++;
        end else begin
            a2 = 1'b0;
        end
        q1.push_back(model(e1, a1, PD1, FW1));
        q2.push_back(model(e2, a2, PD2, FW2));
    end

    // ---------------- monitor ------------------------------------------------
    exp_t w1, w2, g1, g2;
    initial forever begin
        @(negedge clk);
        if (q1.size() > 0) begin
            w1 = q1.pop_front();
            g1 = '{int'(if1.col), int'(if1.row), int'(if1.vid_on), int'(if1.hsync),
                   int'(if1.vsync), int'(if1.line_start), int'(if1.frame_start),
                   int'(if1.frame_cnt)};
            check_state("dut1", w1, g1);
            check_bit("dut1_pix_ce", int'(if1.pix_ce),
                      (en1 && (e1 % PD1 == PD1 - 1)) ? 1 : 0);
        end
        if (q2.size() > 0) begin
            w2 = q2.pop_front();
            g2 = '{int'(if2.col), int'(if2.row), int'(if2.vid_on), int'(if2.hsync),
                   int'(if2.vsync), int'(if2.line_start), int'(if2.frame_start),
                   int'(if2.frame_cnt)};
            check_state("dut2", w2, g2);
            check_bit("dut2_pix_ce", int'(if2.pix_ce),
                      (en2 && (e2 % PD2 == PD2 - 1)) ? 1 : 0);
        end
    end

    // Frame period of the divided instance over uninterrupted running.
    int cyc = 0, last_fs = 0, periods = 0;
    bit run_ok = 1'b0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst2 || !en2) run_ok = 1'b0;
        if (if2.frame_start === 1'b1) begin
            if (run_ok) begin
                check_bit("dut2_frame_period", cyc - last_fs, HT * VT * PD2);
                periods++;
            end
            last_fs = cyc;
            run_ok  = 1'b1;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus -----------------------------------------------
    initial begin
        bit found;

        // Reset for two clocks, then free-run past the fourth frame start.
        tick(2);
        rst1 = 1'b1; rst2 = 1'b1;
        tick(250);

        // Stop dut1 for 5 clocks at (3,0).
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (if1.col == CW'(3) && if1.row == CW'(0)) found = 1'b1;
        end
        if (!found) begin
            bad++; total++;
            $display("FAIL wait_col3_row0 timed out");
        end
        en1 = 1'b0;
        tick(5);
        en1 = 1'b1;
        tick(3);

        // Reset dut1 mid-frame at (4,1), then let it restart.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (if1.col == CW'(4) && if1.row == CW'(1)) found = 1'b1;
        end
        if (!found) begin
            bad++; total++;
            $display("FAIL wait_col4_row1 timed out");
        end
        rst1 = 1'b0;
        tick(1);
        rst1 = 1'b1;
        tick(300);

        // Drop dut2 enable exactly on the last divider phase.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (if2.pix_ce === 1'b1) found = 1'b1;
        end
        if (!found) begin
            bad++; total++;
            $display("FAIL wait_pix_ce timed out");
        end
        tick(4);
        en2 = 1'b0;
        tick(3);
        en2 = 1'b1;
        tick(20);

        // Randomised enable and occasional reset on both instances.
        for (int i = 0; i < 400; i++) begin
            en1  = ($urandom_range(0, 3) != 0);
            rst1 = ($urandom_range(0, 63) != 0);
            en2  = ($urandom_range(0, 3) != 0);
            rst2 = ($urandom_range(0, 63) != 0);
            tick(1);
        end
        rst1 = 1'b1; rst2 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        tick(3);

        check_bit("dut2_periods_seen", (periods >= 1) ? 1 : 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA raster timing generator, successor to the fixed sync generator in the display path.
- Adds:
  - explicit back-porch parameters;
  - per-axis sync polarity;
  - an integrated pixel-clock-enable divider, so it runs from a fast system clock;
  - a run/stop enable;
  - line/frame start strobes;
  - a wrapping frame counter.
- Sits between the system clock domain and the pixel/colour generators, which consume `col`/`row`/`vid_on` and the start strobes.

## Interface

Parameters:
- `HDISP`, 640: visible pixels per line
- `HFP`, 16: horizontal front porch, pixels
- `HPW`, 96: hsync pulse width, pixels
- `HBP`, 48: horizontal back porch, pixels; must be ≥1
- `VDISP`, 480: visible lines per frame
- `VFP`, 10: vertical front porch, lines
- `VPW`, 2: vsync pulse width, lines
- `VBP`, 33: vertical back porch, lines; must be ≥1
- `HSYNC_POL`, 0: active level of hsync
- `VSYNC_POL`, 0: active level of vsync
- `PIX_DIV`, 1: system clocks per pixel; must be ≥1
- `CNT_WIDTH`, 11: width of `col`/`row`; must hold HTOT-1 and VTOT-1
- `FRAME_WIDTH`, 8: width of `frame_cnt`

Ports:
- `clk` in 1: system clock; all logic on rising edge
- `rst` in 1: synchronous, active-low reset (`rst`=0 resets)
- `en` in 1: run enable; 0 freezes all timing state
- `pix_ce` out 1: pixel clock enable; combinational from divider state and `en`
- `col` out CNT_WIDTH: horizontal count, 0..HTOT-1
- `row` out CNT_WIDTH: vertical count, 0..VTOT-1
- `vid_on` out 1: high when `col`<HDISP and `row`<VDISP
- `hsync` out 1: horizontal sync at polarity HSYNC_POL
- `vsync` out 1: vertical sync at polarity VSYNC_POL
- `line_start` out 1: one-clk pulse when `col` becomes 0
- `frame_start` out 1: one-clk pulse when (`col`,`row`) becomes (0,0)
- `frame_cnt` out FRAME_WIDTH: completed-frame count, wraps modulo 2^FRAME_WIDTH

## Operation

- HTOT = HDISP+HFP+HPW+HBP; VTOT = VDISP+VFP+VPW+VBP.
- **Divider**
  - Register `div`, 0..PIX_DIV-1.
  - `pix_ce` = `en` && `div`==PIX_DIV-1.
  - When `en`=1, `div` increments and wraps to 0 after PIX_DIV-1.
  - When PIX_DIV=1, `pix_ce`=`en`.
- **Counters** (advance only on edges where `pix_ce`=1)
  - `col` increments; at HTOT-1 it wraps to 0 and `row` increments.
  - `row` wraps to 0 after VTOT-1.
- **Decode** (every output besides `pix_ce` is a register)
  - Outputs are loaded from the next-state counter values, so `vid_on`/`hsync`/`vsync` always correspond to the current `col`/`row`, with no skew and no glitches.
  - hsync active iff HDISP+HFP ≤ `col` < HDISP+HFP+HPW.
  - vsync active iff VDISP+VFP ≤ `row` < VDISP+VFP+VPW.
  - vsync is decoded from `row` only and is held for whole lines.
- **Strobes and frame counter**
  - `line_start`=1 for exactly one clk after any edge on which `col` wrapped to 0.
  - `frame_start`=1 for exactly one clk after the wrap to (0,0).
  - `frame_cnt` increments on that same edge.
  - The strobe width is one clk, independent of PIX_DIV.
- **`en`=0**
  - `div`, counters, `frame_cnt`, `vid_on` and syncs hold.
  - `line_start`/`frame_start` are 0.

## Timing

- **Reset values** (while `rst`=0, applied on the clock edge)
  - `div`=0, `col`=HTOT-1, `row`=VTOT-1.
  - `vid_on`=0, `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL.
  - `line_start`=0, `frame_start`=0, `frame_cnt`=0.
  - The reset position lies in both back porches, which is why HBP and VBP must be ≥1.
- **First advance after reset release**
  - Occurs on the edge ending the PIX_DIV-th clock with `rst`=1 and `en`=1.
  - Then `col`=0, `row`=0, `vid_on`=1, `line_start`=1, `frame_start`=1, `frame_cnt`=1.
- **Frame period:** HTOT·VTOT·PIX_DIV clocks with `en` held high.
- **Latency:** zero cycles from counter to decode; all are registered on the same edge.
- **Reset mid-frame:** returns to the reset values on the next edge; no partial strobe.
- **`en` and reset together:** `rst`=0 has priority over `en`.
- **`en` dropped when `div`=PIX_DIV-1:** `pix_ce`=0 that cycle and no advance occurs.

## Test plan

Common parameters: HDISP=6, HFP=1, HPW=1, HBP=2 (HTOT=10); VDISP=2, VFP=1, VPW=1, VBP=2 (VTOT=6); polarities 0; PIX_DIV=1; `en`=1.

- **Reset:** hold `rst`=0 for 2 clks -> `col`=9, `row`=5, `vid_on`=0, `hsync`=1, `vsync`=1, `frame_cnt`=0, strobes 0.
- **Line timing:**
  - First edge after release -> `col`=0, `row`=0, `frame_start`=`line_start`=1 for one clk, `frame_cnt`=1.
  - `vid_on`=1 for `col` 0..5.
  - `hsync`=0 only at `col`=7.
- **Frame timing:**
  - Over 60 clks: `vsync`=0 for exactly the 10 clks of `row`=3; `vid_on`=0 on rows 2..5.
  - `frame_cnt`=2 at the next (0,0).
  - With FRAME_WIDTH=2, `frame_cnt` reads 0 after the 4th frame start.
- **Divider (PIX_DIV=4):**
  - `pix_ce` high 1 clk in 4.
  - `col` advances every 4 clks.
  - `line_start` is high for 1 clk, not 4.
  - Frame period is 240 clks.
- **Enable:** drop `en` for 5 clks at `col`=3, `row`=0 -> `col`/`vid_on`/syncs hold, no strobes, `pix_ce`=0; the next edge after re-enable gives `col`=4.
- **Reset mid-frame:** `rst`=0 at `row`=1, `col`=4 -> next edge `col`=9, `row`=5, `frame_cnt`=0; after release, the `frame_start` sequence repeats as in the line-timing scenario.
